// File: rtl/cache_line_adaptor.sv
// -----------------------------------------------------------------------------
// cache_line_adaptor
//
// Purpose:
//   Bridges a 256-bit cache-line port to a 64-bit burst memory port. One line
//   request turns into exactly one 4-beat burst. Reads gather four beats into
//   the line buffer; writes present the buffered line one beat at a time.
//
// Ports:
//   clk          in   1    system clock
//   reset_n      in   1    asynchronous active-low reset
//   line_i       in  256   write line from cache
//   line_o       out 256   assembled read line to cache (the line buffer)
//   address_i    in   32   line address from cache
//   read_i       in   1    cache read request (level)
//   write_i      in   1    cache write request (level)
//   resp_o       out  1    one-cycle completion pulse to cache
//   burst_i      in   64   read beat from memory
//   burst_o      out  64   write beat to memory
//   address_o    out  32   latched line address to memory
//   read_o       out  1    memory read request
//   write_o      out  1    memory write request
//   resp_i       in   1    memory beat-valid, one beat per cycle while high
//   dbg_state_o  out  2    current FSM state, for checkers and debug
//
// Handshake:
//   Cache side: a request (read_i or write_i) is accepted on any rising edge
//   where the block is IDLE; it may then be dropped at any time. Completion is
//   signalled by a single-cycle resp_o. Read has priority if both are high.
//   Memory side: read_o / write_o act as "valid" for the whole burst and stay
//   high while memory waits or delivers. resp_i acts as the per-beat
//   "ready/valid": every rising edge with resp_i=1 moves exactly one beat, and
//   the request output drops on the edge that moves the fourth beat.
// -----------------------------------------------------------------------------
module cache_line_adaptor (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic [1:0]   r_cnt;
  logic [255:0] r_buf;
  logic [31:0]  r_addr;

  logic         w_last_beat;
  logic [63:0]  w_cur_beat;

  // The fourth beat is the one that arrives while the counter already reads 3.
  assign w_last_beat = resp_i && (r_cnt == 2'd3);

  // Beat currently selected by the counter (beat 0 is the low 64 bits).
  always_comb begin
    w_cur_beat = r_buf[63:0];
    case (r_cnt)
      2'd0: w_cur_beat = r_buf[63:0];
      2'd1: w_cur_beat = r_buf[127:64];
      2'd2: w_cur_beat = r_buf[191:128];
      2'd3: w_cur_beat = r_buf[255:192];
      default: w_cur_beat = r_buf[63:0];
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (read_i) begin
          w_next_state = ST_READ;
        end else if (write_i) begin
          w_next_state = ST_WRITE;
        end
      end
      ST_READ: begin
        if (w_last_beat) begin
          w_next_state = ST_DONE;
        end
      end
      ST_WRITE: begin
        if (w_last_beat) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        // Requests are not looked at here; a still-high level request is
        // picked up again from IDLE on the following edge.
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: address latch, beat counter and line buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= 2'd0;
      r_buf  <= '0;
      r_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (read_i) begin
            // The buffer is not cleared on a read: every beat slot gets
            // overwritten before resp_o, so the old line stays visible until
            // then.
            r_addr <= address_i;
            r_cnt  <= 2'd0;
          end else if (write_i) begin
            r_addr <= address_i;
            r_buf  <= line_i;
            r_cnt  <= 2'd0;
          end
        end
        ST_READ: begin
          if (resp_i) begin
            case (r_cnt)
              2'd0: r_buf[63:0]    <= burst_i;
              2'd1: r_buf[127:64]  <= burst_i;
              2'd2: r_buf[191:128] <= burst_i;
              2'd3: r_buf[255:192] <= burst_i;
              default: r_buf[63:0] <= burst_i;
            endcase
            r_cnt <= r_cnt + 2'd1;
          end
        end
        ST_WRITE: begin
          if (resp_i) begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: begin
          // DONE: nothing to update; counter has wrapped back to 0.
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign read_o      = (r_state == ST_READ);
  assign write_o     = (r_state == ST_WRITE);
  assign resp_o      = (r_state == ST_DONE);
  assign address_o   = r_addr;
  assign line_o      = r_buf;
  // Driven only during a write burst so memory never sees stale line data.
  assign burst_o     = (r_state == ST_WRITE) ? w_cur_beat : 64'd0;
  assign dbg_state_o = r_state;

  // ---------------------------------------------------------------------------
  // Embedded protocol properties
  // ---------------------------------------------------------------------------
  a_req_exclusive : assert property (
    @(posedge clk) disable iff (!reset_n) !(read_o && write_o));

  a_resp_single : assert property (
    @(posedge clk) disable iff (!reset_n) resp_o |=> !resp_o);

  a_req_not_with_resp : assert property (
    @(posedge clk) disable iff (!reset_n) resp_o |-> !(read_o || write_o));

endmodule

// File: tb/tb_cache_line_adaptor.sv
module tb_cache_line_adaptor;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;
  logic [1:0]   dbg_state_o;

  always #5 clk = ~clk;

  cache_line_adaptor dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .line_i      (line_i),
    .line_o      (line_o),
    .address_i   (address_i),
    .read_i      (read_i),
    .write_i     (write_i),
    .resp_o      (resp_o),
    .burst_i     (burst_i),
    .burst_o     (burst_o),
    .address_o   (address_o),
    .read_o      (read_o),
    .write_o     (write_o),
    .resp_i      (resp_i),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [255:0] exp_q[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand64(), rand64(), rand64(), rand64()};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks. Inputs change at posedge+1 or at negedge; outputs are sampled
  // at negedge. The memory model spends one cycle noticing the request, then
  // waits d cycles, then streams 4 contiguous beats, so the request output is
  // seen high on (1 + d) + 4 negedges.
  // ---------------------------------------------------------------------------
  task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                         input int d, input bit hold_req, input bit both);
    logic [63:0] beats[4];
    int hi, beat, waited, guard;
    bit seen, bad_write, bad_addr, bad_resp;
    for (int i = 0; i < 4; i++) beats[i] = 64'(line >> (64 * i));
    exp_q.push_back(line);
    @(posedge clk); #1;
    read_i = 1'b1; write_i = both; address_i = addr; line_i = rand256();
    @(posedge clk); #1;
    if (!hold_req) read_i = 1'b0;
    write_i = 1'b0; address_i = $urandom;
    hi = 0; beat = 0; waited = 0; guard = 0; seen = 0;
    bad_write = 0; bad_addr = 0; bad_resp = 0;
    while (beat < 4 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (read_o) hi++;
      if (write_o) bad_write = 1;
      if (read_o && address_o !== addr) bad_addr = 1;
      if (resp_o) bad_resp = 1;
      if (read_i && beat >= 1) read_i = 1'b0;
      if (!seen) begin
        seen = read_o; resp_i = 1'b0;
      end else if (waited < d) begin
        waited++; resp_i = 1'b0;
      end else begin
        resp_i = 1'b1; burst_i = beats[beat]; beat++;
      end
    end
    check("rd_timeout", 256'(guard < 200), 256'(1));
    @(negedge clk);
    resp_i = 1'b0; burst_i = rand64();
    check("rd_req_edges", 256'(hi), 256'(d + 5));
    check("rd_flags{wr,addr,resp}", 256'({bad_write, bad_addr, bad_resp}), 256'(0));
    check("rd_resp_pulse", 256'(resp_o), 256'(1));
    check("rd_req_dropped", 256'({read_o, write_o}), 256'(0));
    check("rd_line", line_o, exp_q.pop_front());
    @(negedge clk);
    check("rd_resp_end", 256'(resp_o), 256'(0));
    check("rd_line_hold", line_o, line);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input int d);
    int hi, beat, waited, guard;
    bit seen, bad_read, bad_addr, bad_resp;
    for (int i = 0; i < 4; i++) exp_q.push_back(256'(64'(line >> (64 * i))));
    @(posedge clk); #1;
    write_i = 1'b1; read_i = 1'b0; address_i = addr; line_i = line;
    @(posedge clk); #1;
    write_i = 1'b0; address_i = $urandom; line_i = rand256();
    hi = 0; beat = 0; waited = 0; guard = 0; seen = 0;
    bad_read = 0; bad_addr = 0; bad_resp = 0;
    while (beat < 4 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (write_o) hi++;
      if (read_o) bad_read = 1;
      if (write_o && address_o !== addr) bad_addr = 1;
      if (resp_o) bad_resp = 1;
      if (!seen) begin
        seen = write_o; resp_i = 1'b0;
      end else if (waited < d) begin
        waited++; resp_i = 1'b0;
      end else begin
        resp_i = 1'b1;
        check($sformatf("wr_beat%0d", beat), 256'(burst_o), exp_q.pop_front());
        beat++;
      end
    end
    check("wr_timeout", 256'(guard < 200), 256'(1));
    while (beat < 4) begin
      void'(exp_q.pop_front());
      beat++;
    end
    @(negedge clk);
    resp_i = 1'b0;
    check("wr_req_edges", 256'(hi), 256'(d + 5));
    check("wr_flags{rd,addr,resp}", 256'({bad_read, bad_addr, bad_resp}), 256'(0));
    check("wr_resp_pulse", 256'(resp_o), 256'(1));
    check("wr_req_dropped", 256'({read_o, write_o}), 256'(0));
    @(negedge clk);
    check("wr_resp_end", 256'(resp_o), 256'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [255:0] l;
    int  guard, beat;
    bit  seen, bad;

    reset_n = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0;
    write_i = 1'b0; burst_i = '0; resp_i = 1'b0;

    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (read_o || write_o || resp_o) bad = 1;
    end
    check("rst_reqs_low", 256'(bad), 256'(0));
    reset_n = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (read_o || write_o || resp_o) bad = 1;
    end
    check("rst_reqs_after", 256'(bad), 256'(0));
    check("rst_line", line_o, 256'(0));
    check("rst_addr", 256'(address_o), 256'(0));
    check("rst_burst", 256'(burst_o), 256'(0));

    // Directed read, memory answers as soon as it notices the request.
    do_read(32'h1234_5678, {64'd4, 64'd3, 64'd2, 64'd1}, 0, 1'b0, 1'b0);
    check("rd_directed_line", line_o, {64'd4, 64'd3, 64'd2, 64'd1});

    // Long delay, read_i held until the first beat.
    do_read($urandom, rand256(), 31, 1'b1, 1'b0);

    // Writes at the delay extremes.
    do_write($urandom, rand256(), 0);
    do_write($urandom, rand256(), 31);

    // Read and write requested together: read wins.
    do_read($urandom, rand256(), 3, 1'b0, 1'b1);

    // Back-to-back random traffic.
    for (int i = 0; i < 50; i++)
      do_read($urandom, rand256(), $urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 50; i++)
      do_write($urandom, rand256(), $urandom_range(0, 31));

    // Reset in the middle of a read, while beat 2 is on the bus.
    @(posedge clk); #1;
    read_i = 1'b1; address_i = 32'hCAFE_0040;
    @(posedge clk); #1;
    read_i = 1'b0;
    beat = 0; seen = 0; guard = 0;
    while (beat < 3 && guard < 50) begin
      @(negedge clk);
      guard++;
      if (!seen) begin
        seen = read_o; resp_i = 1'b0;
      end else begin
        resp_i = 1'b1; burst_i = rand64(); beat++;
      end
    end
    check("mid_rst_reach_beat2", 256'(beat), 256'(3));
    #2 reset_n = 1'b0;
    resp_i = 1'b0;
    #1;
    check("mid_rst_outs", 256'({read_o, write_o, resp_o}), 256'(0));
    check("mid_rst_line", line_o, 256'(0));
    check("mid_rst_addr", 256'(address_o), 256'(0));
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_o || read_o || write_o) bad = 1;
    end
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (resp_o || read_o || write_o) bad = 1;
    end
    check("mid_rst_no_resp", 256'(bad), 256'(0));
    do_read($urandom, rand256(), $urandom_range(0, 31), 1'b0, 1'b0);

    check("scoreboard_empty", 256'(exp_q.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
